// File: rtl/xform_param_ctrl.sv
// xform_param_ctrl
// Holds the nine 3-D transform parameters and edits them from two push
// buttons, with press-and-hold auto-repeat.
// Parameter index order is Tx,Ty,Tz,Rx,Ry,Rz,Sx,Sy,Sz (0..8).
//
// Ports:
//   Clock              sole clock, rising edge
//   resetn             synchronous reset, active HIGH despite the name
//   sel[3:0]           target parameter 0..8; 9..15 are ignored
//   switchUp           increment button (level, already synchronised)
//   switchDown         decrement button (level, already synchronised)
//   Tx..Sz[size:0]     registered parameter values
//   TxChanging..SzChanging  registered edit-activity flags, at most one high
module xform_param_ctrl #(
  parameter int size         = 9,
  parameter int REPEAT_DELAY = 12_500_000,
  parameter int REPEAT_RATE  = 2_500_000,
  parameter int HOLD         = 25_000_000,
  parameter int SCALE_ONE    = 100,
  parameter int T_MAX        = 1000
) (
  input  logic            Clock,
  input  logic            resetn,
  input  logic [3:0]      sel,
  input  logic            switchUp,
  input  logic            switchDown,
  output logic [size:0]   Tx,
  output logic [size:0]   Ty,
  output logic [size:0]   Tz,
  output logic [size:0]   Rx,
  output logic [size:0]   Ry,
  output logic [size:0]   Rz,
  output logic [size:0]   Sx,
  output logic [size:0]   Sy,
  output logic [size:0]   Sz,
  output logic            TxChanging,
  output logic            TyChanging,
  output logic            TzChanging,
  output logic            RxChanging,
  output logic            RyChanging,
  output logic            RzChanging,
  output logic            SxChanging,
  output logic            SyChanging,
  output logic            SzChanging
);

  localparam int W = size + 1;
  localparam logic [size:0] T_TOP   = W'(T_MAX);
  localparam logic [size:0] R_TOP   = W'(359);
  localparam logic [size:0] S_TOP   = '1;
  localparam logic [size:0] S_RESET = W'(SCALE_ONE);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [1:0]    state, state_n;
  logic [3:0]    tgt, tgt_n;
  logic [31:0]   cnt, cnt_n;
  logic [31:0]   hold_cnt, hold_n;
  logic          do_step;
  logic [size:0] step_val;
  logic [8:0]    flags, flags_n;
  logic [size:0] prm [0:8];
  logic          dir_valid;

  // Both buttons together count as released.
  assign dir_valid = switchUp ^ switchDown;

  // One step of the target's arithmetic: translate saturates to 0..T_MAX,
  // rotate wraps modulo 360, scale saturates to 1..all-ones.
  function automatic logic [size:0] step_fn(input logic [3:0] idx,
                                            input logic [size:0] v,
                                            input logic up);
    logic [size:0] r;
    r = v;
    if (idx < 4'd3) begin
      if (up) r = (v >= T_TOP) ? T_TOP : v + 1'b1;
      else    r = (v == '0) ? '0 : v - 1'b1;
    end else if (idx < 4'd6) begin
      if (up) r = (v >= R_TOP) ? '0 : v + 1'b1;
      else    r = (v == '0) ? R_TOP : v - 1'b1;
    end else begin
      if (up) r = (v == S_TOP) ? S_TOP : v + 1'b1;
      else    r = (v <= W'(1)) ? W'(1) : v - 1'b1;
    end
    return r;
  endfunction

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    tgt_n   = tgt;
    cnt_n   = cnt;
    hold_n  = hold_cnt;
    do_step = 1'b0;
    case (state)
      IDLE: begin
        if (hold_cnt != 32'd0) hold_n = hold_cnt - 32'd1;
        if (dir_valid && sel <= 4'd8) begin
          tgt_n   = sel;
          do_step = 1'b1;
          cnt_n   = 32'd0;
          state_n = DELAY;
        end
      end
      DELAY: begin
        if (!dir_valid) begin
          state_n = IDLE;
          hold_n  = 32'(HOLD);
        end else if (cnt == 32'(REPEAT_DELAY - 1)) begin
          do_step = 1'b1;
          cnt_n   = 32'd0;
          state_n = REPEAT;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      REPEAT: begin
        if (!dir_valid) begin
          state_n = IDLE;
          hold_n  = 32'(HOLD);
        end else if (cnt == 32'(REPEAT_RATE - 1)) begin
          do_step = 1'b1;
          cnt_n   = 32'd0;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Direction is sampled at the step itself, so a reversal while held
    // takes effect on the next scheduled step without restarting timing.
    step_val = step_fn(tgt_n, prm[tgt_n], switchUp);

    // Flag follows the (possibly new) target, so a press on another
    // parameter drops the previous flag on the same edge.
    flags_n = '0;
    if (state_n != IDLE || hold_n != 32'd0) flags_n[tgt_n] = 1'b1;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge Clock) begin
    if (resetn) begin
      state    <= IDLE;
      tgt      <= 4'd0;
      cnt      <= 32'd0;
      hold_cnt <= 32'd0;
      flags    <= '0;
      // NOTE: the parameter array is reset element by element because each
      // entry must come out of reset with a defined value (T/R zero, S unity).
      for (int i = 0; i < 9; i++) prm[i] <= (i >= 6) ? S_RESET : '0;
    end else begin
      state    <= state_n;
      tgt      <= tgt_n;
      cnt      <= cnt_n;
      hold_cnt <= hold_n;
      flags    <= flags_n;
      if (do_step) prm[tgt_n] <= step_val;
    end
  end

  assign Tx = prm[0];
  assign Ty = prm[1];
  assign Tz = prm[2];
  assign Rx = prm[3];
  assign Ry = prm[4];
  assign Rz = prm[5];
  assign Sx = prm[6];
  assign Sy = prm[7];
  assign Sz = prm[8];

  assign TxChanging = flags[0];
  assign TyChanging = flags[1];
  assign TzChanging = flags[2];
  assign RxChanging = flags[3];
  assign RyChanging = flags[4];
  assign RzChanging = flags[5];
  assign SxChanging = flags[6];
  assign SyChanging = flags[7];
  assign SzChanging = flags[8];

endmodule

// File: tb/tb_xform_param_ctrl.sv
// Testbench for xform_param_ctrl with short timing parameters
// (REPEAT_DELAY=4, REPEAT_RATE=2, HOLD=3). A vector table covers reset,
// taps, rotation wrap, illegal select and both-buttons; hand-written
// sequences cover auto-repeat, retargeting while held, saturation and
// reset during auto-repeat.
module tb_xform_param_ctrl;

  logic       Clock;
  logic       resetn;
  logic [3:0] sel;
  logic       switchUp;
  logic       switchDown;
  logic [9:0] Tx, Ty, Tz, Rx, Ry, Rz, Sx, Sy, Sz;
  logic       TxChanging, TyChanging, TzChanging, RxChanging, RyChanging;
  logic       RzChanging, SxChanging, SyChanging, SzChanging;

  logic [9:0] outv [0:8];
  logic [8:0] flg;

  int checks = 0;
  int errors = 0;

  xform_param_ctrl #(
    .size(9), .REPEAT_DELAY(4), .REPEAT_RATE(2), .HOLD(3),
    .SCALE_ONE(100), .T_MAX(1000)
  ) dut (
    .Clock(Clock), .resetn(resetn), .sel(sel),
    .switchUp(switchUp), .switchDown(switchDown),
    .Tx(Tx), .Ty(Ty), .Tz(Tz), .Rx(Rx), .Ry(Ry), .Rz(Rz),
    .Sx(Sx), .Sy(Sy), .Sz(Sz),
    .TxChanging(TxChanging), .TyChanging(TyChanging), .TzChanging(TzChanging),
    .RxChanging(RxChanging), .RyChanging(RyChanging), .RzChanging(RzChanging),
    .SxChanging(SxChanging), .SyChanging(SyChanging), .SzChanging(SzChanging)
  );

  assign outv[0] = Tx; assign outv[1] = Ty; assign outv[2] = Tz;
  assign outv[3] = Rx; assign outv[4] = Ry; assign outv[5] = Rz;
  assign outv[6] = Sx; assign outv[7] = Sy; assign outv[8] = Sz;
  assign flg = {SzChanging, SyChanging, SxChanging, RzChanging, RyChanging,
                RxChanging, TzChanging, TyChanging, TxChanging};

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic       rst;
    logic [3:0] sel;
    logic       up;
    logic       dn;
    int         idx;    // which parameter to compare
    int         val;    // its expected value after the edge
    logic [8:0] flags;  // expected flag vector after the edge
  } vec_t;

  vec_t vecs [21];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] s,
                       input logic u, input logic d);
    resetn     = r;
    sel        = s;
    switchUp   = u;
    switchDown = d;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic tap(input logic [3:0] s, input logic u);
    drive(1'b0, s, u, ~u);
    tick();
    drive(1'b0, s, 1'b0, 1'b0);
    tick();
  endtask

  int exp_ry [10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  initial begin
    drive(1'b1, 4'd0, 1'b0, 1'b0);

    //           rst   sel    up    dn   idx val   flags
    vecs[0]  = '{1'b1, 4'd0,  1'b0, 1'b0, 0, 0,   9'h000};
    vecs[1]  = '{1'b1, 4'd6,  1'b0, 1'b0, 6, 100, 9'h000};
    vecs[2]  = '{1'b0, 4'd0,  1'b1, 1'b0, 0, 1,   9'h001}; // tap Tx up
    vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1,   9'h001}; // hold 3
    vecs[4]  = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1,   9'h001}; // hold 2
    vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1,   9'h001}; // hold 1
    vecs[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1,   9'h000}; // hold expired
    vecs[7]  = '{1'b0, 4'd3,  1'b0, 1'b1, 3, 359, 9'h008}; // Rx 0-1 wraps
    vecs[8]  = '{1'b0, 4'd3,  1'b0, 1'b0, 3, 359, 9'h008};
    vecs[9]  = '{1'b0, 4'd3,  1'b1, 1'b0, 3, 0,   9'h008}; // Rx 359+1 wraps
    vecs[10] = '{1'b0, 4'd3,  1'b0, 1'b0, 3, 0,   9'h008};
    vecs[11] = '{1'b0, 4'd12, 1'b1, 1'b0, 3, 0,   9'h008}; // illegal sel
    vecs[12] = '{1'b0, 4'd12, 1'b1, 1'b0, 0, 1,   9'h008};
    vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 3, 0,   9'h000};
    vecs[14] = '{1'b0, 4'd0,  1'b1, 1'b1, 0, 1,   9'h000}; // both buttons
    vecs[15] = '{1'b0, 4'd1,  1'b1, 1'b1, 1, 0,   9'h000};
    vecs[16] = '{1'b0, 4'd0,  1'b0, 1'b0, 0, 1,   9'h000};
    vecs[17] = '{1'b0, 4'd2,  1'b1, 1'b0, 2, 1,   9'h004}; // tap Tz up
    vecs[18] = '{1'b0, 4'd2,  1'b0, 1'b0, 2, 1,   9'h004};
    vecs[19] = '{1'b0, 4'd5,  1'b0, 1'b1, 5, 359, 9'h020}; // new target
    vecs[20] = '{1'b0, 4'd5,  1'b0, 1'b0, 5, 359, 9'h020};

    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].rst, vecs[i].sel, vecs[i].up, vecs[i].dn);
      tick();
      check($sformatf("vec%0d value", i), 32'(outv[vecs[i].idx]),
            32'(vecs[i].val));
      check($sformatf("vec%0d flags", i), 32'(flg), 32'(vecs[i].flags));
    end

    // Let the Rz hold expire.
    for (int i = 0; i < 4; i++) tick();
    check("idle flags", 32'(flg), 32'd0);

    // Auto-repeat on Ry: steps at edges 0, 4, 6, 8.
    drive(1'b0, 4'd4, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("repeat Ry edge%0d", k), 32'(Ry), 32'(exp_ry[k]));
    end
    drive(1'b0, 4'd4, 1'b0, 1'b0);
    tick();
    check("release no step Ry", 32'(Ry), 32'd4);
    check("release flag", 32'(flg), 32'h010);
    tick();
    tick();
    check("hold last cycle flag", 32'(flg), 32'h010);
    tick();
    check("hold expired flag", 32'(flg), 32'd0);

    // Hold Tx, move sel to Ty mid-hold, then reverse direction.
    drive(1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    check("retarget first step Tx", 32'(Tx), 32'd2);
    drive(1'b0, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    check("retarget second step Tx", 32'(Tx), 32'd3);
    check("retarget Ty unchanged", 32'(Ty), 32'd0);
    check("retarget flags", 32'(flg), 32'h001);
    drive(1'b0, 4'd1, 1'b0, 1'b1);
    tick();
    check("reverse no early step", 32'(Tx), 32'd3);
    tick();
    check("reverse step Tx", 32'(Tx), 32'd2);
    check("reverse flags", 32'(flg), 32'h001);
    drive(1'b0, 4'd1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) tick();

    // Translate lower bound: Ty at 0, tap down.
    tap(4'd1, 1'b0);
    check("Ty floor", 32'(Ty), 32'd0);

    // Scale lower bound: walk Sx from 100 down to 1, then one more tap.
    for (int k = 0; k < 99; k++) tap(4'd6, 1'b0);
    check("Sx walked to 1", 32'(Sx), 32'd1);
    drive(1'b0, 4'd6, 1'b0, 1'b1);
    tick();
    check("Sx floor value", 32'(Sx), 32'd1);
    check("Sx floor flag", 32'(flg), 32'h040);
    drive(1'b0, 4'd6, 1'b0, 1'b0);
    tick();
    check("Sx floor hold flag", 32'(flg), 32'h040);
    for (int k = 0; k < 3; k++) tick();

    // Translate upper bound: Tz from 1 to 1000, then one more tap.
    for (int k = 0; k < 999; k++) tap(4'd2, 1'b1);
    check("Tz walked to max", 32'(Tz), 32'd1000);
    drive(1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    check("Tz ceiling value", 32'(Tz), 32'd1000);
    check("Tz ceiling flag", 32'(flg), 32'h004);
    drive(1'b0, 4'd2, 1'b0, 1'b0);
    tick();
    check("Tz ceiling after release", 32'(Tz), 32'd1000);
    for (int k = 0; k < 3; k++) tick();

    // Reset in the middle of auto-repeat on Sy.
    drive(1'b0, 4'd7, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) tick();
    check("Sy before reset", 32'(Sy), 32'd103);
    check("Sy flag before reset", 32'(flg), 32'h080);
    drive(1'b1, 4'd7, 1'b1, 1'b0);
    tick();
    check("reset Tx", 32'(Tx), 32'd0);
    check("reset Tz", 32'(Tz), 32'd0);
    check("reset Rz", 32'(Rz), 32'd0);
    check("reset Sx", 32'(Sx), 32'd100);
    check("reset Sy", 32'(Sy), 32'd100);
    check("reset Sz", 32'(Sz), 32'd100);
    check("reset flags", 32'(flg), 32'd0);
    drive(1'b0, 4'd7, 1'b0, 1'b0);
    tick();
    check("post reset Sy", 32'(Sy), 32'd100);
    check("post reset flags", 32'(flg), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
